// File: rtl/arth_pkg.sv
// Shared types and constants for the two-requester arithmetic arbiter.
package arth_pkg;

    localparam int OPW  = 5;  // operand width (signed)
    localparam int RESW = 9;  // result width (signed)

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arth_state_e;

    // Decoded opcode values (only bits [1:0] of the 3-bit opcode carry meaning).
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Observation bundle: FSM state plus the latched request context.
    typedef struct packed {
        arth_state_e state;
        logic [2:0]  opcode;
        logic        id;
        logic        last_grant;
    } arth_dbg_t;

endpackage

// File: rtl/arth_top.sv
// Raw signed arithmetic unit. Produces a 10-bit result so the single
// out-of-range product (-16 * -16 = 256) stays visible to the caller.
// The divisor arrives pre-sanitised so division never sees zero.
module arth_top
    import arth_pkg::*;
(
    input  logic signed [OPW-1:0]  a,
    input  logic signed [OPW-1:0]  b,
    input  logic signed [OPW-1:0]  div_b,
    input  logic        [1:0]      op,
    output logic signed [RESW:0]   result
);

    logic signed [RESW:0] ax;
    logic signed [RESW:0] bx;
    logic signed [RESW:0] dx;

    assign ax = {{(RESW + 1 - OPW){a[OPW-1]}}, a};
    assign bx = {{(RESW + 1 - OPW){b[OPW-1]}}, b};
    assign dx = {{(RESW + 1 - OPW){div_b[OPW-1]}}, div_b};

    // Select the arithmetic operation; SV signed division truncates toward zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = ax + bx;
            OP_SUB:  result = ax - bx;
            OP_MUL:  result = ax * bx;
            default: result = ax / dx;
        endcase
    end

endmodule

// File: rtl/arth_arbiter.sv
// Two-requester arbiter in front of a shared arithmetic unit.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; reqN_ready is only ever high in IDLE for the granted requester,
// and rsp_* hold steady from rsp_valid rising until rsp_valid && rsp_ready.
module arth_arbiter
    import arth_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic signed [OPW-1:0]  req0_in1,
    input  logic signed [OPW-1:0]  req0_in2,
    input  logic        [2:0]      req0_opcode,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic signed [OPW-1:0]  req1_in1,
    input  logic signed [OPW-1:0]  req1_in2,
    input  logic        [2:0]      req1_opcode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic signed [RESW-1:0] rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output arth_dbg_t              dbg
);

    arth_state_e           state;
    arth_state_e           state_nxt;
    logic signed [OPW-1:0] op_a;
    logic signed [OPW-1:0] op_b;
    logic        [2:0]     op_code;
    logic                  op_id;
    logic                  last_grant;
    logic                  grant_id;
    logic                  accept;
    logic signed [OPW-1:0] div_b;
    logic signed [RESW:0]  raw;
    logic signed [RESW-1:0] res_data;
    logic                  res_err;

    // Pick the winner among pending requesters; round-robin favours the one not served last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = RR_EN ? ~last_grant : 1'b0;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Readiness is gated by reset so nothing is offered while rst_n is low.
    assign accept     = rst_n && (state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_EXEC;
            ST_EXEC:                state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Latch the granted operation so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_a       <= grant_id ? req1_in1    : req0_in1;
            op_b       <= grant_id ? req1_in2    : req0_in2;
            op_code    <= grant_id ? req1_opcode : req0_opcode;
            op_id      <= grant_id;
            last_grant <= grant_id;
        end
    end

    // A zero divisor is swapped for 1 so the unit never divides by zero; the result is overridden below.
    assign div_b = (op_b == '0) ? OPW'(1) : op_b;

    arth_top u_arth_top (
        .a      (op_a),
        .b      (op_b),
        .div_b  (div_b),
        .op     (op_code[1:0]),
        .result (raw)
    );

    // Apply the divide-by-zero and product-overflow corrections.
    always_comb begin
        res_data = raw[RESW-1:0];
        res_err  = 1'b0;
        if (op_code[1:0] == OP_DIV && op_b == '0) begin
            res_data = '0;
            res_err  = 1'b1;
        end else if (op_code[1:0] == OP_MUL && raw > (RESW + 1)'(255)) begin
            res_data = RESW'(255);
            res_err  = 1'b1;
        end
    end

    // Capture the result at the end of the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_data <= res_data;
            rsp_err  <= res_err;
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = op_id;
    assign busy      = (state != ST_IDLE);

    assign dbg.state      = state;
    assign dbg.opcode     = op_code;
    assign dbg.id         = op_id;
    assign dbg.last_grant = last_grant;

endmodule

// File: tb/tb_arth_arbiter.sv
// Bench for arth_arbiter: a round-robin instance is the main target; a
// fixed-priority instance shares its stimulus for the contention scenario.
module tb_arth_arbiter;
    import arth_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [4:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [2:0] req0_opcode, req1_opcode;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
    logic [8:0] rsp_data;
    arth_dbg_t  dbg;

    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_busy;
    logic [8:0] fp_rsp_data;
    arth_dbg_t  fp_dbg;

    int tests = 0;
    int fails = 0;
    int last_g = 1;                 // requester served most recently (model)
    logic [10:0] exp_q[$];          // {id, err, data[8:0]}

    arth_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_opcode(req1_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .dbg(dbg)
    );

    arth_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_opcode(req1_opcode),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err), .busy(fp_busy), .dbg(fp_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference arithmetic from plain integer math: returns {err, data}.
    function automatic logic [9:0] calc(input logic [4:0] a, input logic [4:0] b,
                                        input logic [2:0] op);
        int x, y, r;
        logic e;
        x = int'($signed(a));
        y = int'($signed(b));
        e = 1'b0;
        r = 0;
        case (op[1:0])
            2'd0: r = x + y;
            2'd1: r = x - y;
            2'd2: begin
                r = x * y;
                if (r > 255) begin r = 255; e = 1'b1; end
            end
            default: begin
                if (y == 0) begin r = 0; e = 1'b1; end
                else r = x / y;
            end
        endcase
        return {e, r[8:0]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_g = 1;
    endtask

    // One full transaction: grant, EXEC, RESP with bp stalled cycles, handshake.
    task automatic run_op(input bit v0, input bit v1, input int bp, input bit keep,
                          input bit fp_chk);
        int g;
        logic [10:0] e;
        logic [9:0] efp;
        efp = '0;
        @(negedge clk);
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready = 1'b0;
        #1;
        if (v0 && v1) g = 1 - last_g;
        else          g = v1 ? 1 : 0;
        chk("grant_ready0", req0_ready, (g == 0));
        chk("grant_ready1", req1_ready, (g == 1));
        if (g == 0) e = {1'b0, calc(req0_in1, req0_in2, req0_opcode)};
        else        e = {1'b1, calc(req1_in1, req1_in2, req1_opcode)};
        exp_q.push_back(e);
        if (fp_chk) begin
            chk("fp_ready0", fp_req0_ready, 1'b1);
            chk("fp_ready1", fp_req1_ready, 1'b0);
            efp = calc(req0_in1, req0_in2, req0_opcode);
        end
        @(posedge clk);
        #1;
        last_g = g;
        // Disturb the accepted requester's inputs: the latched op must not care.
        if (g == 0) begin
            req0_in1 = 5'($urandom); req0_in2 = 5'($urandom); req0_opcode = 3'($urandom);
        end else begin
            req1_in1 = 5'($urandom); req1_in2 = 5'($urandom); req1_opcode = 3'($urandom);
        end
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(negedge clk);
        chk("exec_rsp_valid", rsp_valid, 1'b0);
        chk("exec_busy", busy, 1'b1);
        chk("exec_ready0", req0_ready, 1'b0);
        chk("exec_ready1", req1_ready, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, e[10]);
        chk("rsp_data", rsp_data, e[8:0]);
        chk("rsp_err", rsp_err, e[9]);
        if (fp_chk) begin
            chk("fp_rsp_valid", fp_rsp_valid, 1'b1);
            chk("fp_rsp_id", fp_rsp_id, 1'b0);
            chk("fp_rsp_data", fp_rsp_data, efp[8:0]);
            chk("fp_rsp_err", fp_rsp_err, efp[9]);
        end
        for (int i = 0; i < bp; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_id", rsp_id, e[10]);
            chk("bp_rsp_data", rsp_data, e[8:0]);
            chk("bp_rsp_err", rsp_err, e[9]);
            chk("bp_ready0", req0_ready, 1'b0);
            chk("bp_ready1", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_hs_busy", busy, 1'b0);
        chk("post_hs_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid = 1'b1;   // held during reset: must not be offered ready
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        req0_in1 = '0; req0_in2 = '0; req0_opcode = '0;
        req1_in1 = '0; req1_in2 = '0; req1_opcode = '0;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 9'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", busy, 1'b0);
        chk("rst_hold_ready0", req0_ready, 1'b0);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        last_g = 1;

        // Single add: 7 + (-3) = 4.
        req0_in1 = 5'(7); req0_in2 = 5'(-3); req0_opcode = 3'b000;
        run_op(1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Divide by zero, then -7 / 2 = -3.
        req1_in1 = 5'(5); req1_in2 = 5'(0); req1_opcode = 3'b011;
        run_op(1'b0, 1'b1, 0, 1'b0, 1'b0);
        req1_in1 = 5'(-7); req1_in2 = 5'(2); req1_opcode = 3'b011;
        run_op(1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Multiply edges: -16*-16 saturates, -16*15 = -240.
        req0_in1 = 5'(-16); req0_in2 = 5'(-16); req0_opcode = 3'b010;
        run_op(1'b1, 1'b0, 0, 1'b0, 1'b0);
        req0_in1 = 5'(-16); req0_in2 = 5'(15); req0_opcode = 3'b010;
        run_op(1'b1, 1'b0, 0, 1'b0, 1'b0);

        // -16 / -1 = +16 without error; opcode bit 2 ignored.
        req0_in1 = 5'(-16); req0_in2 = 5'(-1); req0_opcode = 3'b111;
        run_op(1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Backpressure for 5 cycles.
        req1_in1 = 5'(9); req1_in2 = 5'(-12); req1_opcode = 3'b001;
        run_op(1'b0, 1'b1, 5, 1'b0, 1'b0);

        // Contention with both requesters always valid: RR alternates, FP always 0.
        do_reset();
        req0_in1 = 5'(3);  req0_in2 = 5'(4);  req0_opcode = 3'b000;
        req1_in1 = 5'(-5); req1_in2 = 5'(6);  req1_opcode = 3'b010;
        for (int k = 0; k < 4; k++) run_op(1'b1, 1'b1, 0, 1'b1, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            int pat;
            pat = $urandom_range(1, 3);
            req0_in1 = 5'($urandom); req0_in2 = 5'($urandom); req0_opcode = 3'($urandom);
            req1_in1 = 5'($urandom); req1_in2 = 5'($urandom); req1_opcode = 3'($urandom);
            run_op(pat[0], pat[1], $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while a response is pending: it must vanish for good.
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        req0_in1 = 5'(2); req0_in2 = 5'(3); req0_opcode = 3'b000;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_rsp_valid", rsp_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rsp_data", rsp_data, 9'd0);
        chk("mid_rst_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_g = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
